// File: rtl/autosym_pkg.sv
// Shared types and sizing helpers for the autosymmetric restriction evaluator.
package autosym_pkg;

   typedef enum logic [1:0] {
      OP_WROW   = 2'd0,
      OP_WTAB   = 2'd1,
      OP_COMMIT = 2'd2,
      OP_CLEAR  = 2'd3
   } cfg_op_e;

   typedef enum logic {
      ST_CFG = 1'b0,
      ST_RUN = 1'b1
   } state_e;

   // Number of cfg_data-wide words needed to hold the 2^k-entry truth table.
   function automatic int tab_words(input int k, input int w);
      return ((1 << k) + w - 1) / w;
   endfunction

endpackage

// File: rtl/autosym_lin_compress.sv
// GF(2) matrix-vector product: z[r] is the parity of the x bits selected by row r of A.
module autosym_lin_compress #(
   parameter int N_IN  = 6,
   parameter int K_RED = 4
) (
   input  logic [K_RED*N_IN-1:0] a,
   input  logic [N_IN-1:0]       x,
   output logic [K_RED-1:0]      z
);

   always_comb begin
      z = '0;
      for (int r = 0; r < K_RED; r++) begin
         z[r] = ^(a[r*N_IN +: N_IN] & x);
      end
   end

endmodule

// File: rtl/autosym_restrict_eval.sv
// Streaming evaluator y = g(A·x): runtime-loaded GF(2) compression matrix and truth table,
// config FSM (CFG/RUN) and a two-stage valid/ready pipeline.
module autosym_restrict_eval
   import autosym_pkg::*;
#(
   parameter int N_IN  = 6,
   parameter int K_RED = 4,
   parameter int CFG_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [1:0]        cfg_op,
   input  logic [9:0]        cfg_addr,
   input  logic [CFG_W-1:0]  cfg_data,
   output logic              cfg_err,
   output logic              running,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N_IN-1:0]   in_x,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_y,
   output logic [K_RED-1:0]  out_z
);

   localparam int TW          = tab_words(K_RED, CFG_W);
   localparam int TAB_ENTRIES = 1 << K_RED;

   // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
   // valid never depends on ready, and a stalled producer holds its payload stable.

   state_e               state_q, state_d;
   cfg_op_e              op;
   logic [N_IN-1:0]      a_q   [K_RED];
   logic [CFG_W-1:0]     tab_q [TW];
   logic [K_RED*N_IN-1:0] a_flat;
   logic [K_RED-1:0]     z_comb;
   logic [K_RED-1:0]     s1_z;
   logic                 s1_valid;
   logic                 s1_adv, s2_adv, in_fire;
   logic                 clear_req, drained, cfg_fire;
   logic                 row_ok, tab_ok, y_lk;

   assign op        = cfg_op_e'(cfg_op);
   assign running   = (state_q == ST_RUN);
   assign drained   = !s1_valid && !out_valid;
   // CLEAR during RUN waits for both stages to empty and blocks new input meanwhile.
   assign clear_req = running && cfg_valid && (op == OP_CLEAR);
   assign cfg_ready = !clear_req || drained;
   assign cfg_fire  = cfg_valid && cfg_ready;
   assign row_ok    = (cfg_addr < 10'(K_RED));
   assign tab_ok    = (cfg_addr < 10'(TW));

   assign s2_adv    = !out_valid || out_ready;
   assign s1_adv    = !s1_valid || s2_adv;
   assign in_ready  = running && !clear_req && s1_adv;
   assign in_fire   = in_valid && in_ready;

   always_comb begin
      a_flat = '0;
      for (int r = 0; r < K_RED; r++) begin
         a_flat[r*N_IN +: N_IN] = a_q[r];
      end
   end

   autosym_lin_compress #(
      .N_IN  (N_IN),
      .K_RED (K_RED)
   ) u_compress (
      .a (a_flat),
      .x (in_x),
      .z (z_comb)
   );

   always_comb begin
      y_lk = 1'b0;
      for (int i = 0; i < TAB_ENTRIES; i++) begin
         if (s1_z == K_RED'(i)) y_lk = tab_q[i / CFG_W][i % CFG_W];
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_CFG:  if (cfg_fire && op == OP_COMMIT) state_d = ST_RUN;
         ST_RUN:  if (cfg_fire && op == OP_CLEAR)  state_d = ST_CFG;
         default: state_d = ST_CFG;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_CFG;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cfg_err <= 1'b0;
         for (int r = 0; r < K_RED; r++) a_q[r] <= '0;
         for (int w = 0; w < TW; w++) tab_q[w] <= '0;
      end else if (cfg_fire) begin
         if (op == OP_CLEAR) begin
            cfg_err <= 1'b0;
            for (int r = 0; r < K_RED; r++) a_q[r] <= '0;
            for (int w = 0; w < TW; w++) tab_q[w] <= '0;
         end else if (running) begin
            cfg_err <= 1'b1;
         end else if (op == OP_WROW) begin
            if (!row_ok) cfg_err <= 1'b1;
            for (int r = 0; r < K_RED; r++) begin
               if (cfg_addr == 10'(r)) a_q[r] <= cfg_data[N_IN-1:0];
            end
         end else if (op == OP_WTAB) begin
            if (!tab_ok) cfg_err <= 1'b1;
            for (int w = 0; w < TW; w++) begin
               if (cfg_addr == 10'(w)) tab_q[w] <= cfg_data;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_z      <= '0;
         out_valid <= 1'b0;
         out_y     <= 1'b0;
         out_z     <= '0;
      end else begin
         if (s1_adv) begin
            s1_valid <= in_fire;
            if (in_fire) s1_z <= z_comb;
         end
         // Output payload only moves when a new result arrives, so it holds while idle.
         if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               out_y <= y_lk;
               out_z <= s1_z;
            end
         end
      end
   end

endmodule
